// File: rtl/kpn_adder_scheduler.sv
// Round-robin arbiter sharing one registered adder; grant->rsp_valid 2 cycles, 4-cycle issue, RESP holds until rsp_ready[g].
// Define KPN_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module kpn_adder_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           add_entry_1,
  output logic [DATA_WIDTH-1:0]           add_entry_2,
  input  logic [DATA_WIDTH-1:0]           add_result,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  busy_q;

  logic [IDX_W-1:0]      search_base;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W:0]        cand;
  logic                  found;
  logic                  rsp_done;

  assign rsp_done = (state_q == RESP) && rsp_ready[gnt_q];

`ifdef KPN_SCHED_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W:0]   gnt_inc;

  assign search_base = rr_ptr_q;
  assign gnt_inc     = {1'b0, gnt_q} + (IDX_W+1)'(1);

  // Pointer moves only when a response is actually handed off.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rsp_done) begin
      rr_ptr_d = (gnt_inc == (IDX_W+1)'(NUM_REQ)) ? '0 : gnt_inc[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // First valid requester at or above search_base, wrapping at NUM_REQ-1.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, search_base} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_d = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          gnt_d       = sel_idx;
          opa_d       = req_a[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          opb_d       = req_b[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          req_ready_d = NUM_REQ'(1) << sel_idx;
        end
      end
      GRANT: state_d = EXEC;
      EXEC: begin
        rsp_data_d  = add_result;
        rsp_valid_d = NUM_REQ'(1) << gnt_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_done) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_ready   = req_ready_q;
  assign add_entry_1 = opa_q;
  assign add_entry_2 = opb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_kpn_adder_scheduler.sv
// Directed bench for kpn_adder_scheduler with a registered adder model on the adder port.
module tb_kpn_adder_scheduler;
  localparam int DW = 16;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     add_entry_1, add_entry_2, add_result;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [NR-1:0]     rsp_ready;
  logic              busy;

  logic [DW-1:0]     ta [NR];
  logic [DW-1:0]     tbv[NR];
  logic [DW-1:0]     fsum[NR];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                g2;

  kpn_adder_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_entry_1(add_entry_1), .add_entry_2(add_entry_2),
    .add_result(add_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) add_result <= add_entry_1 + add_entry_2;

  assign req_a = {ta[3], ta[2], ta[1], ta[0]};
  assign req_b = {tbv[3], tbv[2], tbv[1], tbv[0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_table();
    ta[0] = 16'h1111; tbv[0] = 16'h0101;
    ta[1] = 16'h2222; tbv[1] = 16'h0202;
    ta[2] = 16'h3333; tbv[2] = 16'h0303;
    ta[3] = 16'h4444; tbv[3] = 16'h0404;
  endtask

  // One full transaction: grant edge, EXEC, RESP, back to IDLE.
  task automatic xact(input logic [NR-1:0] vld, input int g, input logic [DW-1:0] exp_sum,
                      input bit keep, input string tag);
    req_valid = vld;
    step();
    chk({tag, ".ready"}, 32'(req_ready), 32'(1) << g);
    chk({tag, ".busy1"}, 32'(busy), 32'(1));
    if (!keep) req_valid = '0;
    step();
    chk({tag, ".ready_off"}, 32'(req_ready), 32'(0));
    step();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1) << g);
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_sum));
    step();
    chk({tag, ".rsp_off"}, 32'(rsp_valid), 32'(0));
    chk({tag, ".busy0"}, 32'(busy), 32'(0));
  endtask

  initial begin
    fsum[0] = 16'h1212; fsum[1] = 16'h2424; fsum[2] = 16'h3636; fsum[3] = 16'h4848;
    load_table();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;

    // Reset held for two edges with every requester valid.
    step();
    step();
    chk("rst.req_ready", 32'(req_ready), 32'(0));
    chk("rst.rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.add_entry_1", 32'(add_entry_1), 32'(0));
    chk("rst.add_entry_2", 32'(add_entry_2), 32'(0));
    chk("rst.rsp_data", 32'(rsp_data), 32'(0));
    rst_n = 1'b1;
    xact(4'hF, 0, 16'h1212, 1'b0, "first_grant");

    ta[1] = 16'h0003; tbv[1] = 16'h0005;
    xact(4'b0010, 1, 16'h0008, 1'b0, "single");

    ta[0] = 16'hFFFF; tbv[0] = 16'h0002;
    xact(4'b0001, 0, 16'h0001, 1'b0, "overflow");

    // Reset again so the fairness run starts from pointer 0.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    load_table();
    chk("rst2.busy", 32'(busy), 32'(0));

    for (int k = 0; k < 5; k++) begin
`ifdef KPN_SCHED_FIXED_PRIO_EN
      xact(4'hF, 0, fsum[0], 1'b1, "fair");
`else
      xact(4'hF, k % NR, fsum[k % NR], 1'b1, "fair");
`endif
    end
    req_valid = '0;

    // Backpressure on requester 2 while others wait.
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    step();
    chk("bp.ready", 32'(req_ready), 32'(4'b0100));
    req_valid = 4'b1011;
    step();
    step();
    chk("bp.rsp_valid", 32'(rsp_valid), 32'(4'b0100));
    chk("bp.rsp_data", 32'(rsp_data), 32'(16'h3636));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp.hold_valid", 32'(rsp_valid), 32'(4'b0100));
      chk("bp.hold_data", 32'(rsp_data), 32'(16'h3636));
      chk("bp.no_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 4'hF;
    step();
    chk("bp.released", 32'(rsp_valid), 32'(0));
    chk("bp.idle", 32'(busy), 32'(0));
`ifdef KPN_SCHED_FIXED_PRIO_EN
    g2 = 0;
`else
    g2 = 3;
`endif
    step();
    chk("bp.next_grant", 32'(req_ready), 32'(1) << g2);
    req_valid = '0;
    step();
    step();
    chk("bp.next_rsp", 32'(rsp_valid), 32'(1) << g2);
    chk("bp.next_data", 32'(rsp_data), 32'(fsum[g2]));
    step();

    // Leave the pointer nonzero, then reset during EXEC.
    xact(4'b0100, 2, 16'h3636, 1'b0, "pre_rst");
    req_valid = 4'b0010;
    step();
    chk("rexec.ready", 32'(req_ready), 32'(4'b0010));
    req_valid = '0;
    step();
    chk("rexec.busy_exec", 32'(busy), 32'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rexec.busy", 32'(busy), 32'(0));
    chk("rexec.rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rexec.rsp_data", 32'(rsp_data), 32'(0));
    chk("rexec.add_entry_1", 32'(add_entry_1), 32'(0));
    step();
    chk("rexec.no_rsp1", 32'(rsp_valid), 32'(0));
    step();
    chk("rexec.no_rsp2", 32'(rsp_valid), 32'(0));
    xact(4'b1010, 1, 16'h2424, 1'b0, "rexec.ptr0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
